// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - dual-issue instruction fetch queue between icache and decode
//
// Circular buffer of {pc, inst} entries. Fetch pushes up to two instructions
// per cycle (slot 2 implicitly at pc+4); decode pops up to two in program order.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   flush               empty the queue on the next edge (highest priority)
//   in_valid1/2         push slot 1 / slot 2 (slot 2 only with slot 1)
//   in_pc, in_inst1/2   PC of slot 1 and the two instruction words
//   full                count > DEPTH-2; fetch holds its request while high
//   deq1/2              pop head / head+1 (deq2 only with deq1)
//   out_valid1/2        head / head+1 entry present
//   out_pc1/2, out_inst1/2  head and head+1 entries
//   count               current occupancy
module inst_queue #(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid1,
   input  logic                     in_valid2,
   input  logic [31:0]              in_pc,
   input  logic [31:0]              in_inst1,
   input  logic [31:0]              in_inst2,
   output logic                     full,
   input  logic                     deq1,
   input  logic                     deq2,
   output logic                     out_valid1,
   output logic                     out_valid2,
   output logic [31:0]              out_pc1,
   output logic [31:0]              out_inst1,
   output logic [31:0]              out_pc2,
   output logic [31:0]              out_inst2,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [63:0]    mem_q [DEPTH];
   logic [PW-1:0]  head_q, head_d;
   logic [PW-1:0]  tail_q, tail_d;
   logic [CW-1:0]  count_q, count_d;
   logic [PW-1:0]  head_p1;
   logic [PW-1:0]  tail_p1;
   logic [1:0]     push;
   logic [1:0]     pop;
   logic           wr1_en;
   logic           wr2_en;

   always_comb begin
      full       = count_q > CW'(DEPTH - 2);
      out_valid1 = count_q != '0;
      out_valid2 = count_q > CW'(1);
      head_p1    = head_q + PW'(1);
      tail_p1    = tail_q + PW'(1);

      // Eligibility uses the registered full, so the queue never needs to
      // reason about space freed by a same-cycle pop.
      push = 2'd0;
      if (!full && !flush && in_valid1) begin
         push = in_valid2 ? 2'd2 : 2'd1;
      end

      // Pop is bounded by the registered valids, so it can never exceed count.
      pop = {1'b0, deq1 & out_valid1} + {1'b0, deq1 & deq2 & out_valid2};

      wr1_en = push != 2'd0;
      wr2_en = push == 2'd2;

      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         head_d  = head_q + PW'(pop);
         tail_d  = tail_q + PW'(push);
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage is deliberately not reset; validity is carried by count alone.
   always_ff @(posedge clk) begin
      if (wr1_en) begin
         mem_q[tail_q] <= {in_pc, in_inst1};
      end
      if (wr2_en) begin
         mem_q[tail_p1] <= {in_pc + 32'd4, in_inst2};
      end
   end

   assign out_pc1   = mem_q[head_q][63:32];
   assign out_inst1 = mem_q[head_q][31:0];
   assign out_pc2   = mem_q[head_p1][63:32];
   assign out_inst2 = mem_q[head_p1][31:0];
   assign count     = count_q;

endmodule

// File: tb/tb_inst_queue.sv
// tb/tb_inst_queue.sv - scoreboard bench for inst_queue
module tb_inst_queue;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid1;
   logic        in_valid2;
   logic [31:0] in_pc;
   logic [31:0] in_inst1;
   logic [31:0] in_inst2;
   logic        full;
   logic        deq1;
   logic        deq2;
   logic        out_valid1;
   logic        out_valid2;
   logic [31:0] out_pc1;
   logic [31:0] out_inst1;
   logic [31:0] out_pc2;
   logic [31:0] out_inst2;
   logic [4:0]  count;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [63:0] sb [$];
   logic [31:0] pc_next = 32'hBFC0_0000;

   inst_queue #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_valid1  (in_valid1),
      .in_valid2  (in_valid2),
      .in_pc      (in_pc),
      .in_inst1   (in_inst1),
      .in_inst2   (in_inst2),
      .full       (full),
      .deq1       (deq1),
      .deq2       (deq2),
      .out_valid1 (out_valid1),
      .out_valid2 (out_valid2),
      .out_pc1    (out_pc1),
      .out_inst1  (out_inst1),
      .out_pc2    (out_pc2),
      .out_inst2  (out_inst2),
      .count      (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One cycle: drive at negedge, compare current outputs with the scoreboard,
   // then advance the scoreboard by what the coming edge should do.
   task automatic step(input logic v1, input logic v2, input logic d1,
                       input logic d2, input logic fl);
      int          po;
      int          pu;
      logic [31:0] i1;
      logic [31:0] i2;
      @(negedge clk);
      i1        = $urandom;
      i2        = $urandom;
      in_valid1 = v1;
      in_valid2 = v2;
      in_pc     = pc_next;
      in_inst1  = i1;
      in_inst2  = i2;
      deq1      = d1;
      deq2      = d2;
      flush     = fl;

      check("count", 64'(count), 64'(sb.size()));
      check("full", 64'(full), 64'(sb.size() > DEPTH - 2));
      check("out_valid1", 64'(out_valid1), 64'(sb.size() >= 1));
      check("out_valid2", 64'(out_valid2), 64'(sb.size() >= 2));
      if (sb.size() >= 1) begin
         check("head_entry", {out_pc1, out_inst1}, sb[0]);
      end
      if (sb.size() >= 2) begin
         check("second_entry", {out_pc2, out_inst2}, sb[1]);
      end

      po = 0;
      if (d1 && sb.size() >= 1) po = 1;
      if (d1 && d2 && sb.size() >= 2) po = 2;
      pu = 0;
      if (!fl && v1 && sb.size() <= DEPTH - 2) pu = v2 ? 2 : 1;

      if (fl) begin
         sb.delete();
      end else begin
         repeat (po) void'(sb.pop_front());
         if (pu >= 1) sb.push_back({pc_next, i1});
         if (pu == 2) sb.push_back({pc_next + 32'd4, i2});
         pc_next = pc_next + 32'(4 * pu);
      end
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid1 = 1'b0; in_valid2 = 1'b0;
      in_pc = '0; in_inst1 = '0; in_inst2 = '0; deq1 = 1'b0; deq2 = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Reset state, then first 2-wide push and its 1-cycle visibility
      step(0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      check("first_pc1", 64'(out_pc1), 64'h0000_0000_BFC0_0000);
      check("first_pc2", 64'(out_pc2), 64'h0000_0000_BFC0_0004);
      step(0, 0, 1, 1, 0);

      // Fill to DEPTH, push while full is dropped, drain in order
      for (int i = 0; i < DEPTH / 2; i++) step(1, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      check("full_at_depth", 64'(full), 64'd1);
      for (int i = 0; i < DEPTH / 2; i++) step(0, 0, 1, 1, 0);

      // Steady push2/pop2 at count 4 across pointer and 32-bit PC wrap
      pc_next = 32'hFFFF_FFF0;
      step(1, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      for (int i = 0; i < 20; i++) step(1, 1, 1, 1, 0);
      step(0, 0, 1, 1, 0);
      step(0, 0, 1, 1, 0);

      // Single entry: deq2 on one valid entry pops one; lone in_valid2 ignored
      step(1, 0, 0, 0, 0);
      step(0, 0, 1, 1, 0);
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      check("lone_v2_empty", 64'(out_valid1), 64'd0);

      // Flush at count 9 with concurrent push and pop
      for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(1, 1, 1, 1, 1);
      step(1, 0, 0, 0, 0);
      check("tail_after_flush", 64'(dut.tail_q), 64'd0);
      step(0, 0, 0, 0, 0);
      check("flush_push_idx0", dut.mem_q[0], sb[0]);
      step(0, 0, 1, 0, 0);

      // Asynchronous reset mid-cycle with count 5
      step(1, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      @(negedge clk);
      in_valid1 = 1'b0; in_valid2 = 1'b0; deq1 = 1'b0; deq2 = 1'b0;
      check("pre_rst_count", 64'(count), 64'd5);
      #2 rst = 1'b1;
      #1;
      check("async_rst_count", 64'(count), 64'd0);
      check("async_rst_valid1", 64'(out_valid1), 64'd0);
      check("async_rst_valid2", 64'(out_valid2), 64'd0);
      check("async_rst_full", 64'(full), 64'd0);
      sb.delete();
      @(posedge clk);
      #2 rst = 1'b0;
      step(1, 1, 0, 0, 0);
      step(1, 0, 1, 0, 0);
      step(0, 0, 1, 1, 0);
      step(0, 0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
